// File: rtl/uart_rf_loader.sv
`default_nettype none
// ============================================================================
// uart_rf_loader : 8N1 UART receiver that turns {header, data} byte pairs
//                  into single-cycle register-file write strobes.
// Revision 1.0
// ============================================================================
module uart_rf_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       we3,
  output logic [2:0] wa3,
  output logic [7:0] wd3,
  output logic       frame_err,
  output logic [7:0] frames_ok
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {FR_HDR, FR_DAT} fr_state_t;

  logic        rx_meta, rxs;
  rx_state_t   rx_state, rx_next;
  logic [15:0] timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        armed;
  logic        byte_valid;
  logic        tick, go, stop_bad;
  fr_state_t   fr_state, fr_next;
  logic [2:0]  pend_addr;
  logic        hdr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    go       = 1'b0;
    stop_bad = 1'b0;
    tick     = (timer == 16'd0);
    case (rx_state)
      RX_IDLE:  if (!rxs && armed) begin
                  rx_next = RX_START;
                  go      = 1'b1;
                end
      RX_START: if (tick) rx_next = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick) begin
                  rx_next  = RX_IDLE;
                  stop_bad = !rxs;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // armed blocks a low line left behind by a bad stop bit from retriggering
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      timer      <= 16'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      armed      <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      byte_valid <= 1'b0;
      if (go)
        timer <= HALF_M1;
      else if (tick && (rx_state == RX_START || rx_state == RX_DATA))
        timer <= FULL_M1;
      else if (!tick)
        timer <= timer - 16'd1;
      if (rx_state == RX_START && tick)
        bit_cnt <= 3'd0;
      if (rx_state == RX_DATA && tick) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (rx_state == RX_STOP && tick) begin
        byte_valid <= rxs;
        armed      <= rxs;
      end else if (rx_state == RX_IDLE && rxs) begin
        armed <= 1'b1;
      end
    end
  end

  always_comb begin
    hdr_ok  = shreg[7] && (shreg[6:3] == 4'd0);
    fr_next = fr_state;
    if (stop_bad)
      fr_next = FR_HDR;
    else if (byte_valid)
      fr_next = (fr_state == FR_HDR && hdr_ok) ? FR_DAT : FR_HDR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_state  <= FR_HDR;
      pend_addr <= 3'd0;
      we3       <= 1'b0;
      wa3       <= 3'd0;
      wd3       <= 8'd0;
      frame_err <= 1'b0;
      frames_ok <= 8'd0;
    end else begin
      fr_state <= fr_next;
      we3      <= 1'b0;
      if (stop_bad)
        frame_err <= 1'b1;
      if (byte_valid) begin
        if (fr_state == FR_HDR) begin
          if (hdr_ok) pend_addr <= shreg[2:0];
          else        frame_err <= 1'b1;
        end else begin
          we3       <= 1'b1;
          wa3       <= pend_addr;
          wd3       <= shreg;
          frames_ok <= frames_ok + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
